// File: rtl/rtc_pkg.sv
// Shared constants for the RTC multiplexed AD bus: field addresses, mask bit
// order, the transfer command address and the write engine state encoding.
package rtc_pkg;

  localparam int NUM_FIELDS = 9;

  localparam logic [7:0] ADDR_YEAR      = 8'h26;
  localparam logic [7:0] ADDR_MES       = 8'h25;
  localparam logic [7:0] ADDR_DIA       = 8'h24;
  localparam logic [7:0] ADDR_HORA      = 8'h23;
  localparam logic [7:0] ADDR_MIN       = 8'h22;
  localparam logic [7:0] ADDR_SEG       = 8'h21;
  localparam logic [7:0] ADDR_HORACRONO = 8'h43;
  localparam logic [7:0] ADDR_MINCRONO  = 8'h42;
  localparam logic [7:0] ADDR_SEGCRONO  = 8'h41;

  localparam int BIT_YEAR      = 0;
  localparam int BIT_MES       = 1;
  localparam int BIT_DIA       = 2;
  localparam int BIT_HORA      = 3;
  localparam int BIT_MIN       = 4;
  localparam int BIT_SEG       = 5;
  localparam int BIT_HORACRONO = 6;
  localparam int BIT_MINCRONO  = 7;
  localparam int BIT_SEGCRONO  = 8;

  localparam logic [7:0] CMD_ADDR_DEF = 8'hF1;
  localparam int         CYC_END_DEF  = 31;

  // Index value meaning "no further field selected".
  localparam logic [3:0] NO_FIELD = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_RD = 3'd1,
    ST_LATCH   = 3'd2,
    ST_FIELD   = 3'd3,
    ST_CMD     = 3'd4,
    ST_DONE    = 3'd5
  } wr_state_e;

  function automatic logic [7:0] field_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    field_addr = ADDR_YEAR;
      4'd1:    field_addr = ADDR_MES;
      4'd2:    field_addr = ADDR_DIA;
      4'd3:    field_addr = ADDR_HORA;
      4'd4:    field_addr = ADDR_MIN;
      4'd5:    field_addr = ADDR_SEG;
      4'd6:    field_addr = ADDR_HORACRONO;
      4'd7:    field_addr = ADDR_MINCRONO;
      4'd8:    field_addr = ADDR_SEGCRONO;
      default: field_addr = 8'h00;
    endcase
  endfunction

  // Lowest set mask bit at or above 'from', or NO_FIELD.
  function automatic logic [3:0] first_set(input logic [8:0] mask, input logic [3:0] from);
    first_set = NO_FIELD;
    for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) first_set = 4'(i);
    end
  endfunction

endpackage

// File: rtl/rtc_bus_cycle.sv
// One address-then-data write transaction on the RTC AD bus. The strobe
// registers take the value listed for cycle c on the edge that enters c.
module rtc_bus_cycle #(
  parameter int CYC_END = 31
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] data_i,
  output logic       ad_o,
  output logic       wr_o,
  output logic       rd_o,
  output logic       cs_o,
  output logic [7:0] ad_out_o,
  output logic       last_o
);

  localparam int              CW   = $clog2(CYC_END + 1);
  localparam logic [CW-1:0]   LAST = CW'(CYC_END);

  logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
  logic          run_q, run_d;
  logic          ad_q, ad_d, wr_q, wr_d, cs_q, cs_d;
  logic [7:0]    dat_q, dat_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      ad_q  <= 1'b1;
      wr_q  <= 1'b1;
      cs_q  <= 1'b1;
      dat_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      ad_q  <= ad_d;
      wr_q  <= wr_d;
      cs_q  <= cs_d;
      dat_q <= dat_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    run_d   = run_q;
    ad_d    = ad_q;
    wr_d    = wr_q;
    cs_d    = cs_q;
    dat_d   = dat_q;
    cnt_nxt = cnt_q + 1'b1;
    if (start_i) begin
      // A start on the last cycle chains straight into the next transaction.
      cnt_d = '0;
      run_d = 1'b1;
      ad_d  = 1'b1;
      wr_d  = 1'b1;
      cs_d  = 1'b1;
      dat_d = addr_i;
    end else if (run_q) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_nxt;
        case (int'(cnt_nxt))
          1:       ad_d  = 1'b0;
          2:       cs_d  = 1'b0;
          3:       wr_d  = 1'b0;
          8:       wr_d  = 1'b1;
          9:       cs_d  = 1'b1;
          10:      ad_d  = 1'b1;
          12:      dat_d = data_i;
          15:      cs_d  = 1'b0;
          16:      wr_d  = 1'b0;
          21:      wr_d  = 1'b1;
          22:      cs_d  = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign ad_o     = ad_q;
  assign wr_o     = wr_q;
  assign rd_o     = 1'b1;
  assign cs_o     = cs_q;
  assign ad_out_o = dat_q;
  assign last_o   = run_q && (cnt_q == LAST);

endmodule

// File: rtl/rtc_write_ctrl.sv
// RTC bus-write engine: latches a time/date/chrono image, writes each masked
// field, then issues the transfer command while holding off the reader.
module rtc_write_ctrl
  import rtc_pkg::*;
#(
  parameter int         CYC_END  = CYC_END_DEF,
  parameter logic [7:0] CMD_ADDR = CMD_ADDR_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [8:0] wr_mask,
  input  logic [7:0] year,
  input  logic [7:0] mes,
  input  logic [7:0] dia,
  input  logic [7:0] hora,
  input  logic [7:0] min,
  input  logic [7:0] seg,
  input  logic [7:0] horacrono,
  input  logic [7:0] mincrono,
  input  logic [7:0] segcrono,
  input  logic       AmPm,
  input  logic       rd_busy,
  output logic [7:0] ADout,
  output logic       ad,
  output logic       wr,
  output logic       rd,
  output logic       cs,
  output logic       bus_oe,
  output logic       rd_inhibit,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  wr_state_e  state_q, state_d;
  logic [3:0] idx_q, idx_d, nxt;
  logic [8:0] mask_q;
  logic [7:0] shadow_q [NUM_FIELDS];
  logic [7:0] live_val [NUM_FIELDS];
  logic       latch_en, cyc_start, cyc_last;
  logic [7:0] cyc_addr, cyc_data;

  always_comb begin
    live_val[BIT_YEAR]      = year;
    live_val[BIT_MES]       = mes;
    live_val[BIT_DIA]       = dia;
    live_val[BIT_HORA]      = {AmPm, hora[6:0]};
    live_val[BIT_MIN]       = min;
    live_val[BIT_SEG]       = seg;
    live_val[BIT_HORACRONO] = horacrono;
    live_val[BIT_MINCRONO]  = mincrono;
    live_val[BIT_SEGCRONO]  = segcrono;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) shadow_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (latch_en) begin
        mask_q <= wr_mask;
        for (int i = 0; i < NUM_FIELDS; i++) shadow_q[i] <= live_val[i];
      end
    end
  end

  // Leaving LATCH the shadows are not yet loaded, so the first field is
  // chosen from the live mask; the data byte is only needed at c=12.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nxt       = NO_FIELD;
    latch_en  = 1'b0;
    cyc_start = 1'b0;
    cyc_addr  = CMD_ADDR;
    case (state_q)
      ST_IDLE: begin
        if (wr_req) state_d = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (!rd_busy) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        latch_en  = 1'b1;
        cyc_start = 1'b1;
        nxt       = first_set(wr_mask, 4'd0);
        if (nxt != NO_FIELD) begin
          state_d  = ST_FIELD;
          idx_d    = nxt;
          cyc_addr = field_addr(nxt);
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_FIELD: begin
        if (cyc_last) begin
          cyc_start = 1'b1;
          nxt       = first_set(mask_q, idx_q + 4'd1);
          if (nxt != NO_FIELD) begin
            idx_d    = nxt;
            cyc_addr = field_addr(nxt);
          end else begin
            state_d = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        if (cyc_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cyc_data = (state_q == ST_FIELD) ? shadow_q[idx_q] : 8'h00;

  rtc_bus_cycle #(
    .CYC_END(CYC_END)
  ) u_bus_cycle (
    .clock    (clock),
    .reset    (reset),
    .start_i  (cyc_start),
    .addr_i   (cyc_addr),
    .data_i   (cyc_data),
    .ad_o     (ad),
    .wr_o     (wr),
    .rd_o     (rd),
    .cs_o     (cs),
    .ad_out_o (ADout),
    .last_o   (cyc_last)
  );

  assign busy       = (state_q != ST_IDLE);
  assign rd_inhibit = (state_q != ST_IDLE);
  assign bus_oe     = (state_q == ST_FIELD) || (state_q == ST_CMD);
  assign done       = (state_q == ST_DONE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_rtc_write_ctrl.sv
// Bench for rtc_write_ctrl: decodes bus transactions into {addr,data} pairs
// and compares them, plus latency and arbitration timing, with a field model.
module tb_rtc_write_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr_req = 1'b0;
  logic [8:0] wr_mask = '0;
  logic [7:0] year = '0, mes = '0, dia = '0, hora = '0, min = '0, seg = '0;
  logic [7:0] horacrono = '0, mincrono = '0, segcrono = '0;
  logic       AmPm = 1'b0;
  logic       rd_busy = 1'b0;
  logic [7:0] ADout;
  logic       ad, wr, rd, cs, bus_oe, rd_inhibit, busy, done;
  logic [2:0] state_dbg;

  rtc_write_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .wr_req     (wr_req),
    .wr_mask    (wr_mask),
    .year       (year),
    .mes        (mes),
    .dia        (dia),
    .hora       (hora),
    .min        (min),
    .seg        (seg),
    .horacrono  (horacrono),
    .mincrono   (mincrono),
    .segcrono   (segcrono),
    .AmPm       (AmPm),
    .rd_busy    (rd_busy),
    .ADout      (ADout),
    .ad         (ad),
    .wr         (wr),
    .rd         (rd),
    .cs         (cs),
    .bus_oe     (bus_oe),
    .rd_inhibit (rd_inhibit),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  always #5 clock = ~clock;

  localparam int LIMIT = 1000;

  typedef struct {
    logic [8:0]  mask;
    logic [7:0]  vals [9];
    logic        ampm;
    int          busy_cyc;
    bit          re_req;
    int          exp_lat;
    logic [15:0] exp_first;
  } vec_t;

  int compared = 0;
  int mismatched = 0;

  logic [15:0] exp_q [$];
  logic [15:0] seen_q [$];
  logic [7:0]  cur_addr = '0;
  bit          have_addr = 0;
  logic        prev_wr = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Field model: each field has a fixed address; order is mask bit order.
  function automatic logic [7:0] addr_of(input int i);
    case (i)
      0: return 8'h26;
      1: return 8'h25;
      2: return 8'h24;
      3: return 8'h23;
      4: return 8'h22;
      5: return 8'h21;
      6: return 8'h43;
      7: return 8'h42;
      default: return 8'h41;
    endcase
  endfunction

  function automatic logic [7:0] data_of(input vec_t v, input int i);
    logic [7:0] b;
    b = v.vals[i];
    if (i == 3) b[7] = v.ampm;
    return b;
  endfunction

  function automatic logic [15:0] first_pair(input vec_t v);
    for (int i = 0; i < 9; i++) if (v.mask[i]) return {addr_of(i), data_of(v, i)};
    return 16'hF100;
  endfunction

  task automatic build_expect(input vec_t v);
    exp_q.delete();
    seen_q.delete();
    for (int i = 0; i < 9; i++) if (v.mask[i]) exp_q.push_back({addr_of(i), data_of(v, i)});
    exp_q.push_back(16'hF100);
  endtask

  function automatic vec_t base_vec(input logic [8:0] m);
    vec_t v;
    v.mask      = m;
    v.vals      = '{8'h24, 8'h06, 8'h15, 8'h11, 8'h30, 8'h45, 8'h01, 8'h02, 8'h03};
    v.ampm      = 1'b0;
    v.busy_cyc  = 0;
    v.re_req    = 0;
    v.exp_lat   = 0;
    v.exp_first = 16'h0000;
    return v;
  endfunction

  task automatic drive_inputs(input vec_t v);
    wr_mask   = v.mask;
    year      = v.vals[0];
    mes       = v.vals[1];
    dia       = v.vals[2];
    hora      = v.vals[3];
    min       = v.vals[4];
    seg       = v.vals[5];
    horacrono = v.vals[6];
    mincrono  = v.vals[7];
    segcrono  = v.vals[8];
    AmPm      = v.ampm;
  endtask

  task automatic scramble();
    wr_mask   = 9'($urandom_range(0, 511));
    year      = 8'($urandom_range(0, 255));
    mes       = 8'($urandom_range(0, 255));
    dia       = 8'($urandom_range(0, 255));
    hora      = 8'($urandom_range(0, 255));
    min       = 8'($urandom_range(0, 255));
    seg       = 8'($urandom_range(0, 255));
    horacrono = 8'($urandom_range(0, 255));
    mincrono  = 8'($urandom_range(0, 255));
    segcrono  = 8'($urandom_range(0, 255));
    AmPm      = ~AmPm;
  endtask

  // Bus monitor: address captured on the wr rise with ad low, data on the
  // wr rise with ad high; each completed pair is checked against exp_q.
  task automatic bus_step();
    logic [15:0] pair;
    if (!reset) begin
      have_addr = 0;
      prev_wr   = 1'b1;
    end else begin
      if (prev_wr && !wr) check("wr_fall_cs_oe", 32'({cs, bus_oe}), 32'h1);
      if (!prev_wr && wr) begin
        if (!ad) begin
          cur_addr  = ADout;
          have_addr = 1;
        end else begin
          pair = {cur_addr, ADout};
          seen_q.push_back(pair);
          check("addr_before_data", 32'(have_addr), 32'h1);
          have_addr = 0;
          if (exp_q.size() == 0) check("bus_txn_unexpected", 32'(pair), 32'hFFFF_FFFF);
          else check("bus_txn", 32'(pair), 32'(exp_q.pop_front()));
        end
      end
      prev_wr = wr;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    bus_step();
  endtask

  task automatic run_op(input vec_t v);
    int n, first_ad, inh_bad, busy_after;
    build_expect(v);
    drive_inputs(v);
    rd_busy  = (v.busy_cyc > 0);
    wr_req   = 1'b1;
    first_ad = 0;
    inh_bad  = 0;
    tick();
    n = 1;
    wr_req = 1'b0;
    while (!done && n < LIMIT) begin
      if (n == v.busy_cyc + 1) rd_busy = 1'b0;
      if (n == v.busy_cyc + 4) scramble();
      if (v.re_req && n == 100) wr_req = 1'b1;
      if (n == 101) wr_req = 1'b0;
      if (!rd_inhibit) inh_bad++;
      if (first_ad == 0 && !ad) first_ad = n;
      tick();
      n++;
    end
    rd_busy = 1'b0;
    check("done_seen", 32'(done), 32'h1);
    check("latency", 32'(n), 32'(v.exp_lat));
    check("rd_inhibit_hold", 32'(inh_bad), 32'h0);
    if (v.mask != 0) check("first_ad_fall", 32'(first_ad), 32'(v.busy_cyc + 4));
    check("first_txn", 32'((seen_q.size() > 0) ? seen_q[0] : 16'h0000), 32'(v.exp_first));
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("at_done_busy_oe", 32'({busy, bus_oe}), 32'h2);
    tick();
    check("done_pulse_end", 32'({done, busy}), 32'h0);
    if (v.re_req) begin
      busy_after = 0;
      for (int k = 0; k < 40; k++) begin
        if (busy || done) busy_after++;
        tick();
      end
      check("no_second_op", 32'(busy_after), 32'h0);
    end
  endtask

  vec_t vecs [6];
  vec_t v;
  int   toggles;
  logic [11:0] prev_bus;

  initial begin
    vecs[0] = base_vec(9'h010); vecs[0].vals[4] = 8'h59;
    vecs[0].exp_lat = 67;  vecs[0].exp_first = 16'h2259;
    vecs[1] = base_vec(9'h008); vecs[1].vals[3] = 8'h12; vecs[1].ampm = 1'b1;
    vecs[1].exp_lat = 67;  vecs[1].exp_first = 16'h2392;
    vecs[2] = base_vec(9'h1FF); vecs[2].re_req = 1;
    vecs[2].exp_lat = 323; vecs[2].exp_first = 16'h2624;
    vecs[3] = base_vec(9'h000);
    vecs[3].exp_lat = 35;  vecs[3].exp_first = 16'hF100;
    vecs[4] = base_vec(9'h0A5); vecs[4].busy_cyc = 40;
    vecs[4].exp_lat = 203; vecs[4].exp_first = 16'h2624;
    vecs[5] = base_vec(9'h100); vecs[5].vals[8] = 8'h47;
    vecs[5].exp_lat = 67;  vecs[5].exp_first = 16'h4147;

    // Reset defaults and quiet bus afterwards.
    reset = 1'b0;
    repeat (4) tick();
    check("rst_strobes_low", 32'({ad, wr, rd, cs}), 32'hF);
    reset = 1'b1;
    tick();
    check("rst_strobes", 32'({ad, wr, rd, cs}), 32'hF);
    check("rst_adout", 32'(ADout), 32'h0);
    check("rst_flags", 32'({bus_oe, rd_inhibit, busy, done}), 32'h0);
    toggles  = 0;
    prev_bus = {ad, wr, rd, cs, ADout};
    for (int k = 0; k < 100; k++) begin
      tick();
      if ({ad, wr, rd, cs, ADout} !== prev_bus) toggles++;
      prev_bus = {ad, wr, rd, cs, ADout};
    end
    check("idle_no_toggle", 32'(toggles), 32'h0);

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // Reset at c=16 of the third field, then a clean restart.
    v = base_vec(9'h1FF);
    build_expect(v);
    drive_inputs(v);
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    for (int n = 1; n < 83; n++) tick();
    check("pre_reset_wr_low", 32'({wr, bus_oe}), 32'h1);
    reset = 1'b0;
    #1;
    check("mid_reset_strobes", 32'({ad, wr, rd, cs}), 32'hF);
    check("mid_reset_flags", 32'({bus_oe, rd_inhibit, busy, done}), 32'h0);
    check("mid_reset_adout", 32'(ADout), 32'h0);
    check("mid_reset_pairs", 32'(seen_q.size()), 32'h2);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    v = base_vec(9'h1FF);
    v.vals[0] = 8'h99;
    v.exp_lat = 323;
    v.exp_first = 16'h2699;
    run_op(v);

    // Randomized operations against the field model.
    for (int r = 0; r < 8; r++) begin
      v = base_vec(9'($urandom_range(0, 511)));
      for (int j = 0; j < 9; j++) v.vals[j] = 8'($urandom_range(0, 255));
      v.ampm      = 1'($urandom_range(0, 1));
      v.busy_cyc  = $urandom_range(0, 6);
      v.exp_lat   = 35 + 32 * $countones(v.mask) + v.busy_cyc;
      v.exp_first = first_pair(v);
      run_op(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rtc_write_ctrl.md
# rtc_write_ctrl

Bus-write engine for the external RTC's multiplexed AD bus; the write-side counterpart placed directly upstream of the RTC scan reader on the same bus. On a request it latches a time/date/chrono image. It then drives address-then-data write transactions for every field selected in a mask, followed by one transfer command. The read scan is inhibited for the whole operation. A top-level mux grants the shared bus pins to this block while `bus_oe` is high.

## Interface
Parameters:
- `CYC_END`, 31: last cycle index of one field transaction (32 cycles per field).
- `CMD_ADDR`, 8'hF1: address of the transfer command issued after the fields.

Ports:
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_req`  in  1  one-cycle start pulse.
- `wr_mask`  in  9  field enables: bit0 year, 1 mes, 2 dia, 3 hora, 4 min, 5 seg, 6 horacrono, 7 mincrono, 8 segcrono.
- `year`, `mes`, `dia`, `hora`, `min`, `seg`, `horacrono`, `mincrono`, `segcrono`  in  8 each  BCD values to write.
- `AmPm`  in  1  replaces bit7 of `hora` on the bus.
- `rd_busy`  in  1  reader currently mid-scan.
- `ADout`  out  8  AD bus drive value.
- `ad`, `wr`, `rd`, `cs`  out  1 each  bus strobes, active-low except `ad`.
- `bus_oe`  out  1  this block owns the bus.
- `rd_inhibit`  out  1  holds off new reader scans.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Field addresses, fixed, in issue order: year 26h, mes 25h, dia 24h, hora 23h, min 22h, seg 21h, horacrono 43h, mincrono 42h, segcrono 41h. Unmasked fields are skipped with no bus cycles.
- hora data byte = {AmPm, hora[6:0]}.
- FSM states:
  - IDLE: on `wr_req`, go to WAIT_RD.
  - WAIT_RD: `rd_inhibit`=1; hold until `rd_busy`=0, then LATCH.
  - LATCH: capture all value inputs and `wr_mask` into shadow registers; later input changes are ignored. Go to FIELD at the first set mask bit, else CMD.
  - FIELD: run one transaction; at cycle `CYC_END`, go to the next set bit, else CMD.
  - CMD: run one transaction with address `CMD_ADDR` and data 00h.
  - DONE: pulse `done`, return to IDLE.
- A mask of 0 still issues CMD.
- `wr_req` is ignored while `busy`=1.
- `busy` = state ≠ IDLE. `rd_inhibit` = state ∉ {IDLE}. `bus_oe` = state ∈ {FIELD, CMD}.

## Timing
- Transaction cycle counter c runs 0..`CYC_END` and resets to 0 on every field entry. Register updates per cycle:
  - c=0: ad=1, wr=1, rd=1, cs=1, ADout=address.
  - c=1: ad=0. c=2: cs=0. c=3: wr=0. c=8: wr=1. c=9: cs=1. c=10: ad=1.
  - c=12: ADout=data. c=15: cs=0. c=16: wr=0. c=21: wr=1. c=22: cs=1.
  - Otherwise, hold.
- `rd` stays 1 throughout.
- Address is stable from c=0 through c=11. Data is stable from c=12 through `CYC_END`.
- Latency from `wr_req` to `done`, with `rd_busy`=0: 1 (WAIT_RD) + 1 (LATCH) + 32·(popcount(mask)+1) + 1 cycles. Full mask: 323 cycles.
- Reset values, all outputs: ad=1, wr=1, rd=1, cs=1, ADout=00h, bus_oe=0, rd_inhibit=0, busy=0, done=0. State=IDLE, counter=0, shadows=0.
- Reset asserted mid-transaction forces these values immediately, asynchronously. No partial transaction resumes.
- `wr_req` coinciding with `rd_busy`=1: wait in WAIT_RD indefinitely. No timeout.

## Structure
- Shared package `rtc_pkg`: field address constants, mask bit indices, `CMD_ADDR`, FSM state encoding. The reader uses the same address constants.
- One natural sub-module: `rtc_bus_cycle`. It takes an address, data and a start pulse, and generates the c=0..`CYC_END` strobe sequence plus a last-cycle flag. The top handles mask walking and the FSM.

## Test plan
- Reset defaults: hold `reset`=0, then release → all outputs at listed reset values; no strobe toggles for 100 cycles.
- Single field: mask=010h, min=59h, `wr_req` → one transaction to 22h with data 59h, then CMD to F1h/00h. `done` arrives 67 cycles after `wr_req`.
- hora with AmPm: mask=008h, hora=12h, AmPm=1 → data byte 92h at address 23h.
- Reader arbitration: `rd_busy`=1 at request, dropped 40 cycles later → `rd_inhibit` high throughout; first `ad` fall occurs 3 cycles after `rd_busy` falls. Inputs changed after LATCH do not alter bus data.
- Full mask plus re-request: mask=1FFh → addresses 26,25,24,23,22,21,43,42,41,F1 in order. A `wr_req` pulsed mid-operation is ignored; a single `done` arrives after 323 cycles.
- Reset mid-op: drop `reset` at c=16 of the third field → `cs`/`wr`=1 and `bus_oe`=0 immediately. A new `wr_req` after release restarts from the first masked field.
